// File: rtl/instr_sequencer.sv
// Program sequencer: preloads datapath registers from an init table, then issues a stored program.
// Optional define SEQ_HALT_OP_EN: opcode 4'hF in RUN ends the run without being issued.
module instr_sequencer #(
    parameter int unsigned AW        = 4,
    parameter logic [3:0]  INIT_OP   = 4'h0,
    parameter logic [15:0] NOP_INSTR = 16'h7000
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          start_i,
    input  logic          hold_i,
    input  logic [AW:0]   prog_len_i,
    input  logic [4:0]    init_len_i,
    input  logic          load_we_i,
    input  logic          load_sel_i,
    input  logic [AW-1:0] load_addr_i,
    input  logic [15:0]   load_data_i,
    output logic [15:0]   instruction_o,
    output logic [15:0]   data_init_o,
    output logic          init_sel_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [AW:0]   pc_o
);

    localparam logic [AW:0] ProgMax = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] PcOne   = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StInit, StRun, StDone} state_e;

    state_e        state_q, state_d;
    logic [4:0]    idx_q, idx_d;
    logic [AW:0]   pc_q, pc_d;
    logic [AW:0]   prog_len_q, prog_len_d;
    logic [4:0]    init_len_q, init_len_d;
    logic          hold_q;
    logic [15:0]   instr_q, instr_d;
    logic [15:0]   dinit_q, dinit_d;
    logic          isel_q, isel_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [15:0]   prog_mem [2**AW];
    logic [15:0]   init_tab [16];
    logic [15:0]   prog_rd;
    logic [AW:0]   prog_clamp;
    logic [4:0]    init_clamp;
    logic          halt;

    // Tables are only writable while idle and are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (load_we_i && state_q == StIdle) begin
            if (load_sel_i) begin
                init_tab[4'(load_addr_i)] <= load_data_i;
            end else begin
                prog_mem[load_addr_i] <= load_data_i;
            end
        end
    end

    assign prog_rd    = prog_mem[pc_q[AW-1:0]];
    assign prog_clamp = (prog_len_i > ProgMax) ? ProgMax : prog_len_i;
    assign init_clamp = (init_len_i > 5'd16) ? 5'd16 : init_len_i;

`ifdef SEQ_HALT_OP_EN
    assign halt = (prog_rd[15:12] == 4'hF);
`else
    assign halt = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pc_d       = pc_q;
        prog_len_d = prog_len_q;
        init_len_d = init_len_q;
        instr_d    = NOP_INSTR;
        dinit_d    = '0;
        isel_d     = 1'b1;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                // done_q marks the done-pulse cycle, where a start must be ignored.
                if (start_i && !done_q) begin
                    idx_d      = '0;
                    pc_d       = '0;
                    prog_len_d = prog_clamp;
                    init_len_d = init_clamp;
                    if (init_clamp != '0)      state_d = StInit;
                    else if (prog_clamp != '0) state_d = StRun;
                    else                       state_d = StDone;
                end
            end
            StInit: begin
                busy_d = 1'b1;
                isel_d = 1'b0;
                if (!hold_q) begin
                    instr_d = {INIT_OP, idx_q[3:0], 8'h00};
                    dinit_d = init_tab[idx_q[3:0]];
                    idx_d   = idx_q + 5'd1;
                    if (idx_q == init_len_q - 5'd1) begin
                        state_d = (prog_len_q != '0) ? StRun : StDone;
                    end
                end
            end
            StRun: begin
                busy_d = 1'b1;
                if (!hold_q) begin
                    if (halt) begin
                        state_d = StDone;
                    end else begin
                        instr_d = prog_rd;
                        pc_d    = pc_q + PcOne;
                        if (pc_q == prog_len_q - PcOne) state_d = StDone;
                    end
                end
            end
            StDone: begin
                busy_d  = 1'b1;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            pc_q       <= '0;
            prog_len_q <= '0;
            init_len_q <= '0;
            hold_q     <= 1'b0;
            instr_q    <= NOP_INSTR;
            dinit_q    <= '0;
            isel_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pc_q       <= pc_d;
            prog_len_q <= prog_len_d;
            init_len_q <= init_len_d;
            hold_q     <= hold_i;
            instr_q    <= instr_d;
            dinit_q    <= dinit_d;
            isel_q     <= isel_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign instruction_o = instr_q;
    assign data_init_o   = dinit_q;
    assign init_sel_o    = isel_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign pc_o          = pc_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed testbench for instr_sequencer: fixed vectors with hand-computed expected outputs.
module tb_instr_sequencer;

    localparam int unsigned AW  = 4;
    localparam logic [15:0] NOP = 16'h7000;

    logic          clk = 1'b0;
    logic          reset, start, hold, load_we, load_sel;
    logic [AW:0]   prog_len;
    logic [4:0]    init_len;
    logic [AW-1:0] load_addr;
    logic [15:0]   load_data;
    logic [15:0]   instr, dinit;
    logic          isel, busy, done;
    logic [AW:0]   pc;

    int errors = 0;
    int checks = 0;

    logic [15:0] b_instr [6] = '{16'h0000, 16'h0100, 16'h2012, 16'h1312, 16'h7000, 16'h7000};
    logic [15:0] b_dinit [6] = '{16'h0005, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    logic        b_isel  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        b_busy  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        b_done  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [AW:0] b_pc    [6] = '{5'd0, 5'd0, 5'd1, 5'd2, 5'd2, 5'd2};

    instr_sequencer #(.AW(AW), .INIT_OP(4'h0), .NOP_INSTR(NOP)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start),
        .hold_i       (hold),
        .prog_len_i   (prog_len),
        .init_len_i   (init_len),
        .load_we_i    (load_we),
        .load_sel_i   (load_sel),
        .load_addr_i  (load_addr),
        .load_data_i  (load_data),
        .instruction_o(instr),
        .data_init_o  (dinit),
        .init_sel_o   (isel),
        .busy_o       (busy),
        .done_o       (done),
        .pc_o         (pc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic load(input logic sel, input logic [AW-1:0] a, input logic [15:0] d);
        load_we = 1'b1; load_sel = sel; load_addr = a; load_data = d;
        step();
        load_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++; if (instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h want %h", instr, NOP); end
        checks++; if (dinit !== 16'h0) begin errors++; $display("FAIL reset_dinit: got %h want 0", dinit); end
        checks++; if (isel !== 1'b1) begin errors++; $display("FAIL reset_isel: got %b want 1", isel); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
        checks++; if (pc !== 5'd0) begin errors++; $display("FAIL reset_pc: got %0d want 0", pc); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        load(1'b1, 4'd0, 16'h0005);
        load(1'b1, 4'd1, 16'h0003);
        load(1'b0, 4'd0, 16'h2012);
        load(1'b0, 4'd1, 16'h1312);
        init_len = 5'd2; prog_len = 5'd2; start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (instr !== NOP || busy !== 1'b0) begin errors++; $display("FAIL basic_latency: got %h/%b want %h/0", instr, busy, NOP); end
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (instr !== b_instr[k] || dinit !== b_dinit[k] || isel !== b_isel[k] ||
                busy !== b_busy[k] || done !== b_done[k] || pc !== b_pc[k]) begin
                errors++;
                $display("FAIL basic_cycle%0d: got %h/%h/%b/%b/%b/%0d want %h/%h/%b/%b/%b/%0d", k,
                         instr, dinit, isel, busy, done, pc,
                         b_instr[k], b_dinit[k], b_isel[k], b_busy[k], b_done[k], b_pc[k]);
            end
            if (k == 4) start = 1'b1;
            if (k == 5) start = 1'b0;
        end
        step();
        checks++; if (busy !== 1'b0 || instr !== NOP) begin errors++; $display("FAIL start_in_done_ignored: got busy=%b instr=%h want 0/%h", busy, instr, NOP); end
    endtask

    task automatic test_zero_len();
        init_len = 5'd0; prog_len = 5'd0; start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_early_done: got %b want 0", done); end
        step();
        checks++; if (done !== 1'b1 || instr !== NOP || busy !== 1'b1) begin errors++; $display("FAIL zero_done: got done=%b instr=%h busy=%b want 1/%h/1", done, instr, busy, NOP); end
        step();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_after: got done=%b busy=%b want 0/0", done, busy); end
    endtask

    task automatic test_hold();
        load(1'b0, 4'd2, 16'h3456);
        init_len = 5'd0; prog_len = 5'd3; start = 1'b1;
        step();
        start = 1'b0; hold = 1'b1;
        step();
        checks++; if (instr !== 16'h2012 || pc !== 5'd1) begin errors++; $display("FAIL hold_word0: got %h pc=%0d want 2012 pc=1", instr, pc); end
        for (int k = 0; k < 3; k++) begin
            step();
            if (k == 1) hold = 1'b0;
            checks++;
            if (instr !== NOP || pc !== 5'd1 || isel !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL hold_nop%0d: got %h pc=%0d isel=%b want %h pc=1 isel=1", k, instr, pc, isel, NOP);
            end
        end
        step();
        checks++; if (instr !== 16'h1312 || pc !== 5'd2) begin errors++; $display("FAIL hold_word1: got %h pc=%0d want 1312 pc=2", instr, pc); end
        step();
        checks++; if (instr !== 16'h3456 || pc !== 5'd3) begin errors++; $display("FAIL hold_word2: got %h pc=%0d want 3456 pc=3", instr, pc); end
        step();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL hold_done: got %b want 1", done); end
        step();
    endtask

    task automatic test_lock_and_clamp();
        int n, bad;
        logic seen;
        for (int i = 0; i < 16; i++) load(1'b0, 4'(i), 16'h2000 | 16'(i));
        init_len = 5'd0; prog_len = 5'd20; start = 1'b1;
        step();
        start = 1'b0;
        n = 0; bad = 0; seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (done) begin seen = 1'b1; break; end
            if (busy && instr !== NOP) begin
                if (instr !== (16'h2000 | 16'(n))) bad++;
                n++;
            end
            if (c == 3) begin
                load_we = 1'b1; load_sel = 1'b0; load_addr = 4'd5; load_data = 16'hDEAD; start = 1'b1;
            end else if (c == 4) begin
                load_sel = 1'b1; load_addr = 4'd0; load_data = 16'hBEEF; start = 1'b0;
            end else if (c == 5) begin
                load_we = 1'b0;
            end
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL clamp_done_seen: got %b want 1", seen); end
        checks++; if (n != 16) begin errors++; $display("FAIL clamp_count: got %0d want 16", n); end
        checks++; if (bad != 0) begin errors++; $display("FAIL clamp_order: got %0d wrong words want 0", bad); end
        step();
        init_len = 5'd1; prog_len = 5'd6; start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++; if (dinit !== 16'h0005) begin errors++; $display("FAIL lock_init_tab: got %h want 0005", dinit); end
        for (int k = 0; k < 6; k++) step();
        checks++; if (instr !== 16'h2005) begin errors++; $display("FAIL lock_prog_mem: got %h want 2005", instr); end
        step();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL lock_done: got %b want 1", done); end
        step();
    endtask

    task automatic test_reset_mid_run();
        init_len = 5'd0; prog_len = 5'd16; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (instr !== NOP || isel !== 1'b1 || busy !== 1'b0 || pc !== 5'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset: got %h/%b/%b/%0d/%b want %h/1/0/0/0", instr, isel, busy, pc, done, NOP);
        end
        step();
        checks++; if (busy !== 1'b0 || instr !== NOP) begin errors++; $display("FAIL midrun_abandon: got busy=%b instr=%h want 0/%h", busy, instr, NOP); end
    endtask

    task automatic test_halt();
        load(1'b0, 4'd0, 16'h2012);
        load(1'b0, 4'd1, 16'hF000);
        load(1'b0, 4'd2, 16'h1312);
        init_len = 5'd0; prog_len = 5'd3; start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++; if (instr !== 16'h2012) begin errors++; $display("FAIL halt_word0: got %h want 2012", instr); end
        step();
`ifdef SEQ_HALT_OP_EN
        checks++; if (instr !== NOP || busy !== 1'b1) begin errors++; $display("FAIL halt_nop: got %h busy=%b want %h/1", instr, busy, NOP); end
        step();
        checks++; if (done !== 1'b1 || pc !== 5'd1) begin errors++; $display("FAIL halt_done: got done=%b pc=%0d want 1/1", done, pc); end
`else
        checks++; if (instr !== 16'hF000) begin errors++; $display("FAIL nohalt_word1: got %h want f000", instr); end
        step();
        checks++; if (instr !== 16'h1312) begin errors++; $display("FAIL nohalt_word2: got %h want 1312", instr); end
        step();
        checks++; if (done !== 1'b1 || pc !== 5'd3) begin errors++; $display("FAIL nohalt_done: got done=%b pc=%0d want 1/3", done, pc); end
`endif
        step();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; hold = 1'b0; load_we = 1'b0; load_sel = 1'b0;
        prog_len = '0; init_len = '0; load_addr = '0; load_data = '0;
        test_reset();
        test_basic();
        test_zero_len();
        test_hold();
        test_lock_and_clamp();
        test_reset_mid_run();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Program sequencer that drives the register-file/ALU datapath from the issuing side. It produces the datapath's `Instruction`, `DataInit` and `InitSel` inputs. A run has two phases:
- **INIT:** preloads datapath registers from an internal init table, with `InitSel=0` so write data comes from `DataInit`.
- **RUN:** issues a stored program one instruction per cycle, with `InitSel=1` so write data comes from the ALU.

The host loads both tables while the block is idle, pulses `start`, and waits for `done`.

## Interface
Parameters:
- `AW`, default 4: program memory address width; depth is 2^AW words.
- `INIT_OP`, default 4'h0: opcode used for INIT writes. It must decode to a register-writing op.
- `NOP_INSTR`, default 16'h7000: word driven whenever nothing is issued. It must decode to a non-writing op.

Ports (sync reset, active-high, single clock):
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a run. Sampled only in IDLE.
- `hold` in 1: stall request during INIT/RUN.
- `prog_len` in AW+1: number of program words to issue. Clamped to 2^AW.
- `init_len` in 5: number of registers to preload. Clamped to 16.
- `load_we` in 1: table write strobe. Honoured only in IDLE.
- `load_sel` in 1: table select. 0 = program memory, 1 = init table.
- `load_addr` in AW: write address. The init table uses the low 4 bits.
- `load_data` in 16: write data.
- `Instruction` out 16: instruction to the datapath. Registered.
- `DataInit` out 16: init data to the datapath. Registered.
- `InitSel` out 1: datapath write-data select. 0 = DataInit, 1 = ALU. Registered.
- `busy` out 1: high in INIT, RUN and DONE.
- `done` out 1: one-cycle pulse at the end of a run.
- `pc` out AW+1: index of the next program word to issue.

## Operation
- Storage:
  - Program memory: 2^AW × 16.
  - Init table: 16 × 16.
  - Writes are synchronous. Neither table is cleared by reset.
- States: IDLE, INIT, RUN, DONE.
- IDLE:
  - Outputs: `Instruction=NOP_INSTR`, `DataInit=0`, `InitSel=1`, `busy=0`.
  - `start=1` goes to INIT if `init_len≠0`, else to RUN if `prog_len≠0`, else to DONE.
  - The internal index `idx` and `pc` are cleared on start.
- INIT, per non-held cycle:
  - Outputs: `Instruction={INIT_OP, idx[3:0], 8'h00}`, `DataInit=init_tab[idx]`, `InitSel=0`.
  - Then `idx` increments.
  - After word `init_len-1` is issued, go to RUN, or to DONE if `prog_len=0`.
- RUN, per non-held cycle:
  - Outputs: `Instruction=prog_mem[pc]`, `DataInit=0`, `InitSel=1`.
  - Then `pc` increments.
  - After word `prog_len-1` is issued, go to DONE.
- DONE: lasts one cycle. `done=1`, outputs as in IDLE, then return to IDLE.
- `hold=1` in INIT/RUN:
  - The next output cycle is `Instruction=NOP_INSTR` with the current `InitSel` phase value kept.
  - `idx` and `pc` are frozen.
  - The same word is issued after `hold` drops. No word is skipped or duplicated.
- `start` is ignored outside IDLE. `load_we` is ignored outside IDLE and the tables are unchanged.
- Reset at any time:
  - Go to IDLE the next cycle with IDLE output values.
  - `done=0`, `pc=0`.
  - A partially issued run is abandoned.

## Timing
- All outputs are registered.
- Input sampled at edge t affects outputs after edge t+1. This applies to `start` and to `hold`.
- Start-to-first-issue latency is 1 cycle. The first INIT (or RUN) word is valid in the cycle after `start` is sampled.
- Unheld run length, from the first issue cycle to the `done` pulse inclusive: `init_len + prog_len + 1` cycles.
- A `start` asserted in the same cycle as the `done` pulse is ignored. A new run needs `start` asserted in IDLE.
- A load in IDLE at edge t is readable by a `start` at edge t+1 or later.

## Configuration
- `SEQ_HALT_OP_EN` defined:
  - In RUN, a fetched word with opcode 4'hF is not issued.
  - `NOP_INSTR` is driven for that cycle and the state moves to DONE next, regardless of remaining `prog_len`.
  - `pc` stops at the halt word's index.
- `SEQ_HALT_OP_EN` undefined: 4'hF words are issued like any other word, and only `prog_len` ends RUN.

## Test plan
- Reset with outputs mid-RUN → next cycle `Instruction=NOP_INSTR`, `InitSel=1`, `busy=0`, `pc=0`, `done=0`.
- Load init words `0x0005`, `0x0003` and program words `0x2012`, `0x1312`. Set `init_len=2`, `prog_len=2`, pulse `start` → exact sequence:
  - INIT: `{INIT_OP,0,00}`/`0x0005`/0, then `{INIT_OP,1,00}`/`0x0003`/0.
  - RUN: `0x2012`/1, then `0x1312`/1.
  - Then `done` for 1 cycle, 5 cycles total.
- `init_len=0`, `prog_len=0`, `start` → `done` the cycle after start, no non-NOP issue.
- `hold=1` for 3 cycles after the first RUN word (`prog_len=3`) → 3 NOP cycles, then words 1 and 2 once each, with `pc` frozen at 1 during the hold.
- `load_we` and `start` during RUN → table contents unchanged and run not restarted. Then `prog_len=5'd20` with AW=4 → exactly 16 words issued.
- With `SEQ_HALT_OP_EN`, program `0x2012`, `0xF000`, `0x1312` with `prog_len=3` → `0x2012` issued, then NOP, then `done`, `pc=1`. Without the macro, all 3 words are issued.
